// File: rtl/sensor_conditioner.sv
// -----------------------------------------------------------------------------
// sensor_conditioner
//
// Purpose:
//   Conditions N_CH asynchronous sensor inputs. Each channel is synchronised
//   with two flops, debounced with a stability counter, and turned into edge
//   pulses. Rising edges raise a sticky event flag that the downstream buzzer
//   state machine acknowledges. A rising edge that arrives while the previous
//   event is still unacknowledged raises a sticky overrun flag.
//
// Ports:
//   clk           in   1     system clock, rising edge
//   rst           in   1     asynchronous active-high reset
//   ena           in   1     channel-processing enable (synchroniser ignores it)
//   sensor_raw    in   N_CH  asynchronous raw sensor levels
//   evt_ack       in   N_CH  per-channel event acknowledge
//   ovr_clr       in   1     clears every overrun flag
//   sensor_clean  out  N_CH  debounced level (registered)
//   rise_pulse    out  N_CH  one-cycle pulse per debounced 0->1 transition
//   fall_pulse    out  N_CH  one-cycle pulse per debounced 1->0 transition
//   evt_pending   out  N_CH  sticky rising-event flag awaiting acknowledge
//   overrun       out  N_CH  sticky flag: rise seen while event still pending
//
// Handshake: evt_pending[i] is a level-style request; the consumer answers
// with evt_ack[i]=1 for at least one clock. An ack on an idle channel is
// ignored. A new rise on the same edge as an ack keeps the flag set, so the
// consumer never loses an event.
//
// Legal DB_CYCLES range is 2..255.
// -----------------------------------------------------------------------------
module sensor_conditioner #(
    parameter int N_CH      = 8,
    parameter int DB_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ena,
    input  logic [N_CH-1:0] sensor_raw,
    input  logic [N_CH-1:0] evt_ack,
    input  logic            ovr_clr,
    output logic [N_CH-1:0] sensor_clean,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] fall_pulse,
    output logic [N_CH-1:0] evt_pending,
    output logic [N_CH-1:0] overrun
);

    // Counter width is ceil(log2(DB_CYCLES)), never less than one bit.
    localparam int            CW      = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic [N_CH-1:0] sync1_q, sync2_q;
    logic [N_CH-1:0] clean_q, clean_d;
    logic [N_CH-1:0] rise_q, rise_d;
    logic [N_CH-1:0] fall_q, fall_d;
    logic [N_CH-1:0] pend_q, pend_d;
    logic [N_CH-1:0] ovr_q, ovr_d;
    logic [CW-1:0]   cnt_q [N_CH];
    logic [CW-1:0]   cnt_d [N_CH];

    // Debounce: the counter measures how long the synchronised input has
    // disagreed with the clean level. Any agreement restarts it, so a glitch
    // shorter than DB_CYCLES cycles never reaches the output.
    always_comb begin
        clean_d = clean_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (ena) begin
                if (sync2_q[i] == clean_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_MAX) begin
                    clean_d[i] = ~clean_q[i];
                    cnt_d[i]   = '0;
                    rise_d[i]  = ~clean_q[i];
                    fall_d[i]  = clean_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Event bookkeeping. A new rise wins over a coincident ack; an ack is
    // enough to suppress the overrun on that same edge. A new overrun wins
    // over a coincident ovr_clr.
    always_comb begin
        pend_d = rise_d | (pend_q & ~evt_ack);
        ovr_d  = (ovr_q & {N_CH{~ovr_clr}}) | (rise_d & pend_q & ~evt_ack);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            clean_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            pend_q  <= '0;
            ovr_q   <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            // Synchroniser runs regardless of ena.
            sync1_q <= sensor_raw;
            sync2_q <= sync1_q;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sensor_clean = clean_q;
    assign rise_pulse   = rise_q;
    assign fall_pulse   = fall_q;
    assign evt_pending  = pend_q;
    assign overrun      = ovr_q;

endmodule

// File: doc/sensor_conditioner.md
SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

Interface
REQ-001 Parameter N_CH, default 8, number of sensor channels.
REQ-002 Parameter DB_CYCLES, default 4, debounce stability count in clocks; legal range 2..255.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  in  1  system clock; all state changes on rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 ena  in  1  channel-processing enable.
REQ-007 sensor_raw  in  N_CH  asynchronous raw sensor levels; bit i = sensor i.
REQ-008 evt_ack  in  N_CH  per-channel acknowledge from the downstream buzzer state machine.
REQ-009 ovr_clr  in  1  clears all overrun flags.
REQ-010 sensor_clean  out  N_CH  debounced sensor level, registered.
REQ-011 rise_pulse  out  N_CH  one-cycle pulse on each debounced 0->1 transition.
REQ-012 fall_pulse  out  N_CH  one-cycle pulse on each debounced 1->0 transition.
REQ-013 evt_pending  out  N_CH  sticky rising-event flag awaiting acknowledge.
REQ-014 overrun  out  N_CH  sticky flag: a new rising event arrived while the previous one was unacknowledged.

Function
REQ-015 Each channel SHALL pass sensor_raw through a 2-flop synchronizer clocked regardless of ena.
REQ-016 Each channel SHALL keep a debounce counter of ceil(log2(DB_CYCLES)) bits, minimum 1 bit.
REQ-017 With ena=1 and sync output equal to sensor_clean, the counter SHALL clear to 0.
REQ-018 With ena=1, sync != sensor_clean, and counter < DB_CYCLES-1, the counter SHALL increment by 1.
REQ-019 With ena=1, sync != sensor_clean, and counter = DB_CYCLES-1, the block SHALL toggle sensor_clean and clear the counter on the same edge.
REQ-020 A glitch shorter than DB_CYCLES synchronized cycles SHALL NOT change sensor_clean; the counter restarts from 0.
REQ-021 Latency: a raw level held stable from sampling edge 0 SHALL appear on sensor_clean after edge DB_CYCLES+1, i.e. DB_CYCLES+2 clocks; 6 for the default.
REQ-022 rise_pulse[i] and fall_pulse[i] SHALL be high for exactly the one cycle following the edge on which sensor_clean[i] toggles; never both high.
REQ-023 With ena=0, counters and sensor_clean SHALL hold, pulses SHALL be 0, and the synchronizer SHALL keep running.
REQ-024 evt_pending[i] SHALL set on the edge that raises rise_pulse[i] and clear on an edge with evt_ack[i]=1.
REQ-025 When a set and evt_ack[i] coincide, evt_pending[i] SHALL remain 1 (set wins) and overrun SHALL NOT set.
REQ-026 overrun[i] SHALL set when a rising event occurs while evt_pending[i]=1 and evt_ack[i]=0.
REQ-027 overrun SHALL clear only via ovr_clr=1; if ovr_clr coincides with a new overrun condition, overrun SHALL be 1.
REQ-028 evt_ack on a channel with evt_pending=0 SHALL have no effect.
REQ-029 Channels SHALL be fully independent; simultaneous events on all N_CH channels SHALL be handled in the same cycle.

Reset
REQ-030 While rst=1, synchronizer flops, counters, sensor_clean, rise_pulse, fall_pulse, evt_pending and overrun SHALL all be 0, independent of clk.
REQ-031 Reset asserted mid-debounce SHALL discard partial counts; after release, debounce SHALL restart from counter 0.
REQ-032 Reset release SHALL be synchronous to clk; the first functional edge is the first rising clk edge with rst=0.

Verification
REQ-033 Default parameters, rst pulse, sensor_raw=8'h01 held -> sensor_clean=8'h01 after 6 clocks, rise_pulse=8'h01 for 1 cycle, evt_pending=8'h01.
REQ-034 sensor_raw[1] high for 3 clocks, then low -> sensor_clean[1] stays 0, no pulses.
REQ-035 Channel 2 rises, no ack, falls, rises again -> fall_pulse[2] once, overrun[2]=1; ovr_clr=1 for 1 cycle -> overrun[2]=0, evt_pending[2]=1.
REQ-036 evt_ack[2]=1 on the same edge as a new rise on channel 2 -> evt_pending[2]=1, overrun[2]=0.
REQ-037 sensor_raw=8'hFF with ena=0 for 20 clocks -> sensor_clean=8'h00; ena=1 -> sensor_clean=8'hFF exactly 4 clocks later, rise_pulse=8'hFF for 1 cycle.
REQ-038 rst asserted 3 clocks into a debounce on channel 0 -> all outputs 0 immediately; after release with the input still high -> sensor_clean[0]=1 only after the full 6 clocks.
